mmcm_drp_reconfig: RTL and testbench

Sequencer that reprograms an MMCME2_ADV through its DRP port. On a start request it holds the MMCM in reset and walks a caller-supplied table of read-modify-write entries (address, keep-mask, data). It then releases reset, waits for LOCKED and reports done or error. It sits between the clock/reset block and the MMCM instance and is the only DRP master.

---
 rtl/mmcm_drp_reconfig.sv | 210 +++++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_reconfig.sv
// ---------------------------------------------------------------------------
// mmcm_drp_reconfig
//
// Reprograms an MMCME2_ADV through its DRP port. A start request puts the MMCM
// into reset, walks a caller-supplied table of read-modify-write entries,
// releases reset, waits for LOCKED and reports done or a coded error. This
// block is the only DRP master on the MMCM.
//
// Ports:
//   clk, rst_n           controller clock (also MMCM DCLK), async active-low reset
//   start, num_entries   request (sampled in IDLE only) and number of entries
//   busy, done, err      status: busy level, done pulse, sticky error flag
//   err_code             0 none, 1 read DRDY timeout, 2 write DRDY timeout,
//                        3 lock timeout
//   tbl_idx              current table index; tbl_addr/mask/data return the
//                        entry combinationally
//   drp_*                DRP master interface to the MMCM
//   mmcm_rst             MMCM reset, held for the whole reprogramming window
//   mmcm_locked          MMCM LOCKED
//   locked_out           mmcm_locked, forced low while busy
//   dbg_state            current FSM state encoding for observation
//
// DRP handshake: drp_den is a one-cycle request pulse (drp_dwe marks a write
// and is only ever high together with drp_den); the access completes on the
// first cycle drp_drdy is high in the matching wait state. drp_daddr and
// drp_di stay stable from the request cycle until drp_drdy. DRDY arriving in
// any other state is ignored.
// ---------------------------------------------------------------------------
module mmcm_drp_reconfig #(
    parameter int IDXW     = 4,
    parameter int DRDY_TO  = 63,
    parameter int LOCK_TO  = 4095,
    parameter int RST_HOLD = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IDXW:0]   num_entries,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code,
    output logic [IDXW-1:0] tbl_idx,
    input  logic [6:0]      tbl_addr,
    input  logic [15:0]     tbl_mask,
    input  logic [15:0]     tbl_data,
    output logic [6:0]      drp_daddr,
    output logic            drp_den,
    output logic            drp_dwe,
    output logic [15:0]     drp_di,
    input  logic [15:0]     drp_do,
    input  logic            drp_drdy,
    output logic            mmcm_rst,
    input  logic            mmcm_locked,
    output logic            locked_out,
    output logic [3:0]      dbg_state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        HOLD_PRE  = 4'd1,
        RD_REQ    = 4'd2,
        RD_WAIT   = 4'd3,
        WR_REQ    = 4'd4,
        WR_WAIT   = 4'd5,
        HOLD_POST = 4'd6,
        LOCK_WAIT = 4'd7,
        ERR       = 4'd8
    } state_t;

    // One shared counter serves the reset holds and both timeouts.
    localparam int CW = $clog2(LOCK_TO + DRDY_TO + RST_HOLD + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IDXW:0] nent;
    logic [6:0]    daddr_q;
    logic          last_entry;

    assign last_entry = ({1'b0, tbl_idx} == (nent - (IDXW + 1)'(1)));

    // The table answers combinationally to tbl_idx, and tbl_idx only settles
    // on the edge that enters RD_REQ, so the request cycle drives the table
    // address straight through; it is captured for the rest of the access.
    assign drp_daddr  = (state == RD_REQ) ? tbl_addr : daddr_q;
    assign locked_out = busy ? 1'b0 : mmcm_locked;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            nent     <= '0;
            daddr_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            tbl_idx  <= '0;
            drp_den  <= 1'b0;
            drp_dwe  <= 1'b0;
            drp_di   <= '0;
            mmcm_rst <= 1'b0;
        end else begin
            // Strobes are single-cycle; they are raised only on the edge
            // entering RD_REQ/WR_REQ (or LOCK_WAIT->IDLE for done).
            drp_den <= 1'b0;
            drp_dwe <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        nent     <= num_entries;
                        err      <= 1'b0;
                        err_code <= 2'd0;
                        tbl_idx  <= '0;
                        busy     <= 1'b1;
                        mmcm_rst <= 1'b1;
                        cnt      <= '0;
                        state    <= HOLD_PRE;
                    end
                end
                HOLD_PRE: begin
                    if (cnt == CW'(RST_HOLD)) begin
                        cnt <= '0;
                        if (nent == '0) begin
                            state <= HOLD_POST;
                        end else begin
                            drp_den <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RD_REQ: begin
                    daddr_q <= tbl_addr;
                    cnt     <= '0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (drp_drdy) begin
                        drp_di  <= (drp_do & tbl_mask) | (tbl_data & ~tbl_mask);
                        drp_den <= 1'b1;
                        drp_dwe <= 1'b1;
                        state   <= WR_REQ;
                    end else if (cnt == CW'(DRDY_TO - 1)) begin
                        err      <= 1'b1;
                        err_code <= 2'd1;
                        mmcm_rst <= 1'b0;
                        state    <= ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WR_REQ: begin
                    cnt   <= '0;
                    state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (drp_drdy) begin
                        cnt <= '0;
                        if (last_entry) begin
                            state <= HOLD_POST;
                        end else begin
                            tbl_idx <= tbl_idx + IDXW'(1);
                            drp_den <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end else if (cnt == CW'(DRDY_TO - 1)) begin
                        err      <= 1'b1;
                        err_code <= 2'd2;
                        mmcm_rst <= 1'b0;
                        state    <= ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD_POST: begin
                    if (cnt == CW'(RST_HOLD)) begin
                        cnt      <= '0;
                        mmcm_rst <= 1'b0;
                        state    <= LOCK_WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LOCK_WAIT: begin
                    if (mmcm_locked) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CW'(LOCK_TO - 1)) begin
                        err      <= 1'b1;
                        err_code <= 2'd3;
                        state    <= ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// ---------------------------------------------------------------------------
// tb_mmcm_drp_reconfig
//
// Directed bench for mmcm_drp_reconfig. A behavioural DRP slave answers each
// DEN after a programmable latency (or never, for writes when block_wr is
// set) and logs every request; a behavioural MMCM raises LOCKED a set number
// of cycles after reset is released (or never). Expected values below are
// worked out by hand from the block's timing with RST_HOLD=7, DRDY_TO=63,
// LOCK_TO=4095.
// ---------------------------------------------------------------------------
module tb_mmcm_drp_reconfig;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start;
    logic [4:0]  num_entries;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [3:0]  tbl_idx;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_mask, tbl_data;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do   = 16'h0;
    logic        drp_drdy = 1'b0;
    logic        mmcm_rst;
    logic        mmcm_locked = 1'b0;
    logic        locked_out;
    logic [3:0]  dbg_state;

    mmcm_drp_reconfig #(
        .IDXW(4), .DRDY_TO(63), .LOCK_TO(4095), .RST_HOLD(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_entries(num_entries),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_mask(tbl_mask),
        .tbl_data(tbl_data), .drp_daddr(drp_daddr), .drp_den(drp_den),
        .drp_dwe(drp_dwe), .drp_di(drp_di), .drp_do(drp_do),
        .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked),
        .locked_out(locked_out), .dbg_state(dbg_state)
    );

    // ---------------- table ----------------
    logic [6:0]  t_addr [16];
    logic [15:0] t_mask [16];
    logic [15:0] t_data [16];

    assign tbl_addr = t_addr[tbl_idx];
    assign tbl_mask = t_mask[tbl_idx];
    assign tbl_data = t_data[tbl_idx];

    // ---------------- DRP slave + MMCM models ----------------
    logic [15:0] do_tab [128];
    int          drdy_lat   = 1;
    logic        block_wr   = 1'b0;
    int          lock_delay = 0;
    logic        lock_never = 1'b0;

    logic        pending  = 1'b0;
    int          wait_cnt = 0;
    logic [6:0]  pend_addr = 7'h0;
    logic        pend_we   = 1'b0;
    logic [15:0] pend_di   = 16'h0;
    logic        prev_den  = 1'b0;
    int          den_cnt     = 0;
    int          b2b_cnt     = 0;
    int          stable_viol = 0;
    logic [6:0]  log_addr [64];
    logic        log_we   [64];
    logic [15:0] log_di   [64];
    int          lk_cnt = 0;

    always @(posedge clk) begin
        drp_drdy <= 1'b0;
        prev_den <= drp_den;
        if (drp_den && prev_den) b2b_cnt <= b2b_cnt + 1;
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (pending) begin
            if (drp_daddr != pend_addr || (pend_we && drp_di != pend_di))
                stable_viol <= stable_viol + 1;
            if (wait_cnt == 1) begin
                pending  <= 1'b0;
                drp_drdy <= 1'b1;
                drp_do   <= pend_we ? 16'h0 : do_tab[pend_addr];
            end else begin
                wait_cnt <= wait_cnt - 1;
            end
        end
        if (drp_den && rst_n) begin
            log_addr[den_cnt % 64] <= drp_daddr;
            log_we[den_cnt % 64]   <= drp_dwe;
            log_di[den_cnt % 64]   <= drp_di;
            den_cnt <= den_cnt + 1;
            if (!(drp_dwe && block_wr)) begin
                if (drdy_lat <= 1) begin
                    drp_drdy <= 1'b1;
                    drp_do   <= drp_dwe ? 16'h0 : do_tab[drp_daddr];
                end else begin
                    pending   <= 1'b1;
                    wait_cnt  <= drdy_lat - 1;
                    pend_addr <= drp_daddr;
                    pend_we   <= drp_dwe;
                    pend_di   <= drp_di;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (mmcm_rst) begin
            lk_cnt      <= 0;
            mmcm_locked <= 1'b0;
        end else if (lock_never) begin
            mmcm_locked <= 1'b0;
        end else if (lk_cnt >= lock_delay) begin
            mmcm_locked <= 1'b1;
        end else begin
            lk_cnt <= lk_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start in cycle 0, then watch cycles 1.. until done/err or budget.
    // cyc ends as the cycle number in which done or err is first seen.
    task automatic run_seq(input logic [4:0] n, input int budget, input int poke_at,
                           output int cyc, output int rst_cyc, output int busy_cyc,
                           output int gate_bad, output int max_idx);
        @(negedge clk);
        start = 1'b1;
        num_entries = n;
        @(negedge clk);
        start = 1'b0;
        num_entries = 5'd0;
        cyc = 1; rst_cyc = 0; busy_cyc = 0; gate_bad = 0; max_idx = 0;
        while (!(done || err) && cyc < budget) begin
            if (mmcm_rst) rst_cyc++;
            if (busy) busy_cyc++;
            if (busy && locked_out) gate_bad++;
            if (int'(tbl_idx) > max_idx) max_idx = int'(tbl_idx);
            if (cyc == poke_at) begin
                start = 1'b1;
                num_entries = 5'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    // Hand-computed request log for the four-entry run.
    logic [6:0]  e2_addr [8] = '{7'h10, 7'h10, 7'h11, 7'h11, 7'h14, 7'h14, 7'h4E, 7'h4E};
    logic [15:0] e2_di   [4] = '{16'h12FF, 16'h0055, 16'h5555, 16'h8001};

    // ---------------- directed sequence ----------------
    initial begin
        int cyc, rc, bc, gb, mi, base;

        rst_n = 1'b0;
        start = 1'b0;
        num_entries = 5'd0;
        for (int i = 0; i < 16; i++) begin
            t_addr[i] = 7'(i);
            t_mask[i] = 16'hFFFF;
            t_data[i] = 16'h0000;
        end
        for (int i = 0; i < 128; i++) do_tab[i] = 16'h0000;

        // Reset state
        step(3);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_mmcm_rst", 32'(mmcm_rst), 0);
        check("rst_den", 32'(drp_den), 0);
        check("rst_dwe", 32'(drp_dwe), 0);
        check("rst_idx", 32'(tbl_idx), 0);
        check("rst_daddr", 32'(drp_daddr), 0);
        check("rst_di", 32'(drp_di), 0);
        check("rst_state", 32'(dbg_state), 0);
        rst_n = 1'b1;
        step(2);
        check("idle_locked_out", 32'(locked_out), 1);

        // Single entry: DO=0x1234, mask F000, data 0ABC -> DI 0x1ABC
        t_addr[0] = 7'h08; t_mask[0] = 16'hF000; t_data[0] = 16'h0ABC;
        do_tab[8'h08] = 16'h1234;
        drdy_lat = 2; lock_delay = 3;
        base = den_cnt;
        run_seq(5'd1, 200, -1, cyc, rc, bc, gb, mi);
        check("t1_done", 32'(done), 1);
        check("t1_done_cycle", 32'(cyc), 28);
        check("t1_err", 32'(err), 0);
        check("t1_busy_at_done", 32'(busy), 0);
        check("t1_rst_cycles", 32'(rc), 22);
        check("t1_busy_cycles", 32'(bc), 27);
        check("t1_gate", 32'(gb), 0);
        check("t1_den_count", 32'(den_cnt - base), 2);
        check("t1_rd_addr", 32'(log_addr[base % 64]), 32'h08);
        check("t1_rd_we", 32'(log_we[base % 64]), 0);
        check("t1_wr_addr", 32'(log_addr[(base + 1) % 64]), 32'h08);
        check("t1_wr_we", 32'(log_we[(base + 1) % 64]), 1);
        check("t1_wr_di", 32'(log_di[(base + 1) % 64]), 32'h1ABC);
        step(1);
        check("t1_done_pulse", 32'(done), 0);

        // Four entries, DRDY 1 cycle after DEN, immediate relock;
        // a start pulse in cycle 12 must be ignored.
        t_addr[0] = 7'h10; t_mask[0] = 16'h00FF; t_data[0] = 16'h1200;
        t_addr[1] = 7'h11; t_mask[1] = 16'hFF00; t_data[1] = 16'h0055;
        t_addr[2] = 7'h14; t_mask[2] = 16'h0F0F; t_data[2] = 16'h5A5A;
        t_addr[3] = 7'h4E; t_mask[3] = 16'hFFFF; t_data[3] = 16'h1234;
        do_tab[7'h10] = 16'hFFFF; do_tab[7'h11] = 16'h0000;
        do_tab[7'h14] = 16'hA5A5; do_tab[7'h4E] = 16'h8001;
        drdy_lat = 1; lock_delay = 0;
        base = den_cnt;
        run_seq(5'd4, 200, 12, cyc, rc, bc, gb, mi);
        check("t2_done", 32'(done), 1);
        check("t2_done_cycle", 32'(cyc), 35);
        check("t2_busy_with_done", 32'(busy), 0);
        check("t2_rst_cycles", 32'(rc), 32);
        check("t2_gate", 32'(gb), 0);
        check("t2_max_idx", 32'(mi), 3);
        check("t2_final_idx", 32'(tbl_idx), 3);
        check("t2_den_count", 32'(den_cnt - base), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_addr%0d", k), 32'(log_addr[(base + k) % 64]), 32'(e2_addr[k]));
            check($sformatf("t2_we%0d", k), 32'(log_we[(base + k) % 64]), 32'(k % 2));
            if (k % 2 == 1)
                check($sformatf("t2_di%0d", k / 2), 32'(log_di[(base + k) % 64]), 32'(e2_di[k / 2]));
        end
        step(2);
        check("t2_idle_after_poke", 32'(busy), 0);

        // Zero entries: no DRP traffic, 16 cycles of MMCM reset
        base = den_cnt;
        run_seq(5'd0, 200, -1, cyc, rc, bc, gb, mi);
        check("t3_done", 32'(done), 1);
        check("t3_done_cycle", 32'(cyc), 19);
        check("t3_rst_cycles", 32'(rc), 16);
        check("t3_den_count", 32'(den_cnt - base), 0);
        check("t3_gate", 32'(gb), 0);

        // Write DRDY never comes: error code 2
        t_addr[0] = 7'h08; t_mask[0] = 16'hF000; t_data[0] = 16'h0ABC;
        block_wr = 1'b1;
        run_seq(5'd1, 300, -1, cyc, rc, bc, gb, mi);
        check("t4_err", 32'(err), 1);
        check("t4_err_cycle", 32'(cyc), 75);
        check("t4_err_code", 32'(err_code), 2);
        check("t4_no_done", 32'(done), 0);
        check("t4_mmcm_rst", 32'(mmcm_rst), 0);
        check("t4_rst_cycles", 32'(rc), 74);
        step(1);
        check("t4_busy_clear", 32'(busy), 0);
        check("t4_err_sticky", 32'(err), 1);
        check("t4_code_sticky", 32'(err_code), 2);
        check("t4_no_done2", 32'(done), 0);
        block_wr = 1'b0;
        step(3);
        @(negedge clk);
        start = 1'b1;
        num_entries = 5'd0;
        @(negedge clk);
        start = 1'b0;
        check("t4b_err_cleared", 32'(err), 0);
        check("t4b_code_cleared", 32'(err_code), 0);
        check("t4b_busy", 32'(busy), 1);
        step(30);
        check("t4b_idle", 32'(busy), 0);

        // LOCKED never comes: error code 3
        lock_never = 1'b1;
        run_seq(5'd0, 5000, -1, cyc, rc, bc, gb, mi);
        check("t5_err", 32'(err), 1);
        check("t5_err_cycle", 32'(cyc), 4112);
        check("t5_err_code", 32'(err_code), 3);
        check("t5_no_done", 32'(done), 0);
        step(1);
        check("t5_busy_clear", 32'(busy), 0);
        lock_never = 1'b0;
        step(1);
        check("t5_locked_out_follows", 32'(locked_out), 1);

        // Reset asserted during RD_WAIT
        t_addr[0] = 7'h08;
        drdy_lat = 3;
        @(negedge clk);
        start = 1'b1;
        num_entries = 5'd1;
        @(negedge clk);
        start = 1'b0;
        step(9);
        check("t6_in_rd_wait", 32'(dbg_state), 3);
        check("t6_mmcm_rst_pre", 32'(mmcm_rst), 1);
        check("t6_daddr_pre", 32'(drp_daddr), 32'h08);
        check("t6_di_pre", 32'(drp_di), 32'h1ABC);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_mmcm_rst", 32'(mmcm_rst), 0);
        check("t6_den", 32'(drp_den), 0);
        check("t6_daddr", 32'(drp_daddr), 0);
        check("t6_di", 32'(drp_di), 0);
        check("t6_idx", 32'(tbl_idx), 0);
        check("t6_state", 32'(dbg_state), 0);
        step(2);
        rst_n = 1'b1;
        step(4);
        check("t6_idle_after", 32'(busy), 0);
        check("t6_no_done_after", 32'(done), 0);

        // Protocol invariants collected over the whole run
        check("den_back_to_back", 32'(b2b_cnt), 0);
        check("addr_data_stable", 32'(stable_viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
